// File: rtl/uart_arb_pkg.sv
// Shared types, constants and helpers for the UART TX round-robin arbiter.
package uart_arb_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned DATA_W  = MAX_REQ * BYTE_W;

  localparam logic [7:0] DEFAULT_LOCK_BYTE = 8'h0A;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // Extract byte idx from a packed byte vector (byte i at bits [8i+7:8i]).
  function automatic logic [7:0] byte_sel(input logic [DATA_W-1:0] data,
                                          input int unsigned idx);
    return 8'(data >> (BYTE_W * idx));
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-TX-side handshake bundle for uart_tx_arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic                 tx_ready;
  logic [IW-1:0]        grant_id;
  logic                 busy;

  // Master: the requesters plus the UART TX sink around the arbiter.
  modport master (
    output req_valid, req_data, tx_ready,
    input  req_ready, tx_valid, tx_data, grant_id, busy
  );

  // Slave: the arbiter itself.
  modport slave (
    input  req_valid, req_data, tx_ready,
    output req_ready, tx_valid, tx_data, grant_id, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: first set request after last_grant.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [IW-1:0]      grant,
  output logic               any_req
);

  // Scan offsets 1..NUM_REQ so the last winner is checked last.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      if (!any_req && req[IW'((32'(last_grant) + off) % NUM_REQ)]) begin
        any_req = 1'b1;
        grant   = IW'((32'(last_grant) + off) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART TX byte stream among NUM_REQ requesters.
// Define UART_TX_ARB_LOCK_EN to hold a grant until LOCK_BYTE or an idle timeout.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter logic [7:0]  LOCK_BYTE    = DEFAULT_LOCK_BYTE,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  arb_state_e         state;
  arb_state_e         state_nxt;
  logic [IW-1:0]      grant_id;
  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      pick;
  logic               any_req;
  logic               gnt_valid;
  logic               accept;
  logic               release_c;
  logic               tx_valid;
  logic               tx_valid_nxt;
  logic [7:0]         tx_data;
  logic [7:0]         in_byte;
  logic               busy;
  logic [NUM_REQ-1:0] req_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .grant      (pick),
    .any_req    (any_req)
  );

  // A byte moves only when the one-entry output register is free or draining.
  assign gnt_valid = bus.req_valid[grant_id];
  assign accept    = (state == XFER) && gnt_valid && (!tx_valid || bus.tx_ready);
  assign in_byte   = byte_sel(DATA_W'(bus.req_data), 32'(grant_id));

  always_comb begin
    req_ready           = '0;
    req_ready[grant_id] = accept;
  end

`ifdef UART_TX_ARB_LOCK_EN
  localparam int unsigned     TMO_W    = $clog2(LOCK_TIMEOUT) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);

  logic [TMO_W-1:0] idle_cnt;
  logic             eom;
  logic             tmo;

  assign eom       = accept && (in_byte == LOCK_BYTE);
  assign tmo       = (state == XFER) && !gnt_valid && (idle_cnt == TMO_LAST);
  assign release_c = eom || tmo;

  // Counts stalled cycles of the locked requester; saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if ((state != XFER) || accept) begin
      idle_cnt <= '0;
    end else if (!gnt_valid && (idle_cnt != '1)) begin
      idle_cnt <= idle_cnt + TMO_W'(1);
    end
  end
`else
  // One byte per grant; a requester that drops valid also gives up its turn.
  assign release_c = accept || !gnt_valid;

  logic unused_lock_cfg;
  assign unused_lock_cfg = ^{LOCK_BYTE, 32'(LOCK_TIMEOUT)};
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)   state_nxt = XFER;
      XFER:    if (release_c) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
    tx_valid_nxt = accept ? 1'b1 : (tx_valid && !bus.tx_ready);
  end

  // last_grant resets to the top index so requester 0 wins the first round.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && any_req) begin
        grant_id   <= pick;
        last_grant <= pick;
      end
      tx_valid <= tx_valid_nxt;
      if (accept) begin
        tx_data <= in_byte;
      end
      busy <= (state_nxt != IDLE) || tx_valid_nxt;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.tx_valid  = tx_valid;
  assign bus.tx_data   = tx_data;
  assign bus.grant_id  = grant_id;
  assign bus.busy      = busy;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter between NUM_REQ byte-stream requesters using round-robin arbitration. It sits between several on-chip sources and the UART TX byte interface in the FPGA top levels. Example sources are loopback echo, a status reporter and a debug console. Each requester sees a valid/ready handshake. The UART TX sees a single registered valid/ready stream.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..8.
- LOCK_BYTE, 8'h0A: end-of-message byte. Used only when the lock feature is compiled in.
- LOCK_TIMEOUT, 1024: idle cycles after which a held grant is released. Used only when the lock feature is compiled in.
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  system clock.
  - rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*8  packed bytes; requester i occupies bits [8i+7:8i].
- req_ready  out  NUM_REQ  per-requester accept; at most one bit is high in any cycle.
- tx_valid  out  1  byte valid toward UART TX.
- tx_data  out  8  byte toward UART TX.
- tx_ready  in  1  UART TX accepts the byte.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- busy  out  1  high while the FSM is not in IDLE or tx_valid is high.

## Operation
- FSM states: IDLE, XFER.
- IDLE:
  - If any req_valid is high, select the first valid requester searching from last_grant+1, wrapping modulo NUM_REQ.
  - Register grant_id, update last_grant, move to XFER.
  - req_ready is all-zero in IDLE.
- XFER:
  - req_ready[grant_id] = req_valid[grant_id] && (!tx_valid || tx_ready).
  - On a req handshake, load tx_data from req_data[grant_id] and set tx_valid.
- Output register: one entry. tx_valid clears on tx_ready unless a new byte loads in the same cycle; in that case tx_valid stays high and tx_data takes the new byte.
- XFER exit without lock: return to IDLE on the cycle after a byte is accepted. This gives one byte per grant and fair interleaving.
- XFER exit on a dropped request: return to IDLE if req_valid[grant_id] is low while in XFER, without lock only.
- Simultaneous requests: the rotating priority resolves them. The requester granted last has lowest priority next.
- No byte is dropped or duplicated. A requester's data is sampled only in its handshake cycle.

## Timing
- Reset values: tx_valid=0, tx_data=8'h00, req_ready=0, grant_id=0, busy=0, state=IDLE, last_grant=NUM_REQ-1 (so requester 0 wins first), timeout counter=0.
- Cycle N: req_valid rises in IDLE. Cycle N+1: state is XFER and req_ready is high. Cycle N+2: tx_valid is high. Latency is 2 cycles.
- Unlocked throughput: one byte per 2 cycles when tx_ready is held high.
- tx_data stays stable while tx_valid && !tx_ready.
- Reset mid-transfer: a pending tx byte is discarded and the grant is released.

## Configuration
- UART_TX_ARB_LOCK_EN defined:
  - The grant is held in XFER across bytes until the accepted byte equals LOCK_BYTE. The FSM then returns to IDLE the next cycle.
  - A counter increments on each XFER cycle with req_valid[grant_id] low and clears on any handshake.
  - When the counter reaches LOCK_TIMEOUT-1, the FSM forces IDLE.
  - Counter width: $clog2(LOCK_TIMEOUT)+1; it saturates and does not wrap.
- UART_TX_ARB_LOCK_EN undefined: per-byte arbitration only. LOCK_BYTE and LOCK_TIMEOUT are ignored, and no counter logic is built.

## Structure
- Package uart_arb_pkg:
  - state enum (IDLE, XFER).
  - default LOCK_BYTE constant.
  - helper function for packed-byte select.
- Sub-module rr_arbiter:
  - combinational rotating-priority picker.
  - inputs: req vector, last_grant. Outputs: grant index, any_req.
- The top-level FPGA wrapper instantiates uart_tx_arbiter in front of the existing UART TX.

## Test plan
- Single requester 1 sends 8'h55, tx_ready=1: tx_valid at cycle 2 after req_valid with tx_data=8'h55; grant_id=1; req_ready pulses exactly once.
- Requesters 0–3 all valid continuously, unlocked, tx_ready=1: output order 0,1,2,3,0,… with one byte each.
- tx_ready held low 10 cycles with a byte pending: tx_data stays stable, req_ready stays 0, and no new byte is lost.
- Lock enabled:
  - req 2 sends "AB\n" while req 0 is also valid.
  - Required: all three req 2 bytes appear contiguously, then req 3 is skipped because it is not requesting, then req 0 is served.
- Lock enabled, granted requester stalls LOCK_TIMEOUT cycles mid-message: the grant is released and the next valid requester is served.
- rst asserted while tx_valid=1: the next cycle shows tx_valid=0, IDLE state, and requester 0 wins the next arbitration.
